y_shift_reg: RTL and testbench

Y_SHIFT_REG -- requirements
Module: y_shift_reg

---
 rtl/y_shift_reg.sv | 88 ++++++++
 tb/tb_y_shift_reg.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/y_shift_reg.sv
// Y operand register with a multi-cycle barrel-free shifter (one bit per clock).
// Optional macro Y_SHIFT_ROTATE_EN enables the ROR mode (shift_mode=11).
//
// state | meaning
// IDLE  | waiting; y_in loads bus, shift_start begins a shift
// SHIFT | one bit shifted per edge until the counter reaches zero
// DONE  | single-cycle completion pulse, then back to IDLE
module y_shift_reg #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] bus,
    input  logic             y_in,
    input  logic             shift_start,
    input  logic [3:0]       shift_amt,
    input  logic [1:0]       shift_mode,
    output logic [WIDTH-1:0] y_shifted,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [1:0] MODE_LSL = 2'b00;
    localparam logic [1:0] MODE_LSR = 2'b01;
    localparam logic [1:0] MODE_ASR = 2'b10;

    logic [1:0]       state;
    logic [WIDTH-1:0] y_reg;
    logic [3:0]       cnt;
    logic [1:0]       mode_q;
    logic [WIDTH-1:0] y_step;

    always_comb begin
        y_step = y_reg;
        case (mode_q)
            MODE_LSL: y_step = {y_reg[WIDTH-2:0], 1'b0};
            MODE_LSR: y_step = {1'b0, y_reg[WIDTH-1:1]};
            MODE_ASR: y_step = {y_reg[WIDTH-1], y_reg[WIDTH-1:1]};
            default: begin
`ifdef Y_SHIFT_ROTATE_EN
                y_step = {y_reg[0], y_reg[WIDTH-1:1]};
`else
                // Rotate compiled out: Y holds, sequence timing is unchanged.
                y_step = y_reg;
`endif
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            y_reg  <= '0;
            cnt    <= 4'd0;
            mode_q <= MODE_LSL;
        end else begin
            case (state)
                IDLE: begin
                    if (y_in) begin
                        y_reg <= bus;
                    end else if (shift_start) begin
                        mode_q <= shift_mode;
                        cnt    <= shift_amt;
                        state  <= (shift_amt == 4'd0) ? DONE : SHIFT;
                    end
                end
                SHIFT: begin
                    y_reg <= y_step;
                    cnt   <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign y_shifted = y_reg;
    assign busy      = (state == SHIFT);
    assign done      = (state == DONE);

endmodule

// File: tb/tb_y_shift_reg.sv
// Directed self-checking bench for y_shift_reg (default WIDTH=16).
module tb_y_shift_reg;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] bus = 16'h0000;
    logic        y_in = 1'b0;
    logic        shift_start = 1'b0;
    logic [3:0]  shift_amt = 4'd0;
    logic [1:0]  shift_mode = 2'b00;
    logic [15:0] y_shifted;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

    y_shift_reg #(.WIDTH(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .y_in        (y_in),
        .shift_start (shift_start),
        .shift_amt   (shift_amt),
        .shift_mode  (shift_mode),
        .y_shifted   (y_shifted),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [15:0] v, input string tag);
        bus  = v;
        y_in = 1'b1;
        cyc();
        y_in = 1'b0;
        chk({tag, "_load"}, {16'h0, y_shifted}, {16'h0, v});
        chk({tag, "_load_busy"}, {31'h0, busy}, 32'd0);
    endtask

    // Start at edge E0; sample k=0 is just after E0. Expect busy for samples
    // 0..amt-1 and the single done pulse at sample amt.
    task automatic run_shift(input logic [3:0] amt, input logic [1:0] mode,
                             input logic [15:0] exp_y, input bit poke, input string tag);
        int busy_cnt = 0;
        int done_cnt = 0;
        int done_at  = -1;
        shift_amt   = amt;
        shift_mode  = mode;
        shift_start = 1'b1;
        y_in        = 1'b0;
        cyc();
        shift_start = 1'b0;
        shift_amt   = ~amt;
        shift_mode  = ~mode;
        for (int k = 0; k < int'(amt) + 4; k++) begin
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                done_at = k;
            end
            if (poke) begin
                y_in        = (k <= int'(amt));
                shift_start = (k <= int'(amt));
                bus         = 16'hFFFF;
            end
            cyc();
        end
        y_in        = 1'b0;
        shift_start = 1'b0;
        chk({tag, "_busy_cycles"}, busy_cnt, {28'h0, amt});
        chk({tag, "_done_pulses"}, done_cnt, 32'd1);
        chk({tag, "_done_latency"}, done_at, {28'h0, amt});
        chk({tag, "_result"}, {16'h0, y_shifted}, {16'h0, exp_y});
    endtask

    initial begin
        int done_cnt;
        logic [15:0] rot_exp;

        #2;
        chk("reset_y", {16'h0, y_shifted}, 32'h0);
        chk("reset_busy", {31'h0, busy}, 32'd0);
        chk("reset_done", {31'h0, done}, 32'd0);
        cyc();
        rst_n = 1'b1;
        cyc();

        load(16'h5555, "lsl1");
        run_shift(4'd1, 2'b00, 16'hAAAA, 1'b0, "lsl1");

        load(16'h8001, "asr4");
        run_shift(4'd4, 2'b10, 16'hF800, 1'b0, "asr4");

        load(16'h1234, "lsr0");
        run_shift(4'd0, 2'b01, 16'h1234, 1'b0, "lsr0");

`ifdef Y_SHIFT_ROTATE_EN
        rot_exp = 16'h8000;
`else
        rot_exp = 16'h0001;
`endif
        load(16'h0001, "ror1");
        run_shift(4'd1, 2'b11, rot_exp, 1'b0, "ror1");

        load(16'hF0F0, "lsr3");
        run_shift(4'd3, 2'b01, 16'h1E1E, 1'b0, "lsr3");

        load(16'h0003, "lsl15");
        run_shift(4'd15, 2'b00, 16'h8000, 1'b0, "lsl15");

        load(16'h00FF, "poke");
        run_shift(4'd8, 2'b00, 16'hFF00, 1'b1, "poke");
        cyc();
        chk("poke_after_y", {16'h0, y_shifted}, 32'h0000FF00);

        bus         = 16'h0F0F;
        y_in        = 1'b1;
        shift_start = 1'b1;
        shift_amt   = 4'd3;
        shift_mode  = 2'b00;
        cyc();
        y_in        = 1'b0;
        shift_start = 1'b0;
        chk("both_y", {16'h0, y_shifted}, 32'h00000F0F);
        chk("both_busy", {31'h0, busy}, 32'd0);
        cyc();
        chk("both_busy2", {31'h0, busy}, 32'd0);
        chk("both_done2", {31'h0, done}, 32'd0);
        chk("both_y2", {16'h0, y_shifted}, 32'h00000F0F);

        load(16'hFFFF, "rst");
        shift_amt   = 4'd10;
        shift_mode  = 2'b01;
        shift_start = 1'b1;
        cyc();
        shift_start = 1'b0;
        for (int i = 0; i < 4; i++) cyc();
        chk("rst_mid_busy", {31'h0, busy}, 32'd1);
        chk("rst_mid_y", {16'h0, y_shifted}, 32'h00000FFF);
        rst_n = 1'b0;
        #1;
        chk("rst_y", {16'h0, y_shifted}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'd0);
        chk("rst_done", {31'h0, done}, 32'd0);
        cyc();
        cyc();
        rst_n = 1'b1;
        load(16'hA5A5, "post_rst");
        done_cnt = 0;
        for (int i = 0; i < 14; i++) begin
            if (done) done_cnt++;
            cyc();
        end
        chk("post_rst_no_done", done_cnt, 32'd0);
        chk("post_rst_y", {16'h0, y_shifted}, 32'h0000A5A5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
